// File: rtl/spi_bus_controller_pkg.sv
// Shared definitions for the SPI bus controller: SRAM command codes, frame size,
// FSM state encoding and the frame builder.
package spi_bus_controller_pkg;

    localparam logic [7:0] SPI_CMD_READ   = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
    localparam int         SPI_FRAME_BITS = 32;
    localparam int         BIT_CNT_W      = $clog2(SPI_FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } spi_state_t;

    // Read wins when both requests are high; reads shift out a zero data byte.
    function automatic logic [31:0] build_frame(input logic       is_read,
                                                input logic [15:0] address,
                                                input logic [7:0]  wdata);
        logic [7:0] cmd;
        logic [7:0] data;
        if (is_read) begin
            cmd  = SPI_CMD_READ;
            data = 8'h00;
        end else begin
            cmd  = SPI_CMD_WRITE;
            data = wdata;
        end
        return {cmd, address[15:8], address[7:0], data};
    endfunction

endpackage

// File: rtl/spi_bus_controller_clkgen.sv
// SCLK generator: half-period divider plus the SCLK toggle register, with
// strobes marking the clk edge on which SCLK rises or falls.
module spi_bus_controller_clkgen #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic sclk,
    output logic rise_strobe,
    output logic fall_strobe
);

    logic [7:0] div_r;
    logic       sclk_r;
    logic       terminal_s;

    assign terminal_s = (div_r == 8'(CLK_DIV - 1));

    // Divider and SCLK toggle; held at zero / idle-low whenever cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= 8'd0;
            sclk_r <= 1'b0;
        end else if (clear) begin
            div_r  <= 8'd0;
            sclk_r <= 1'b0;
        end else if (enable) begin
            if (terminal_s) begin
                div_r  <= 8'd0;
                sclk_r <= ~sclk_r;
            end else begin
                div_r <= div_r + 8'd1;
            end
        end
    end

    // Strobes are high in the cycle whose closing edge performs the toggle.
    assign rise_strobe = enable & ~clear & terminal_s & ~sclk_r;
    assign fall_strobe = enable & ~clear & terminal_s &  sclk_r;
    assign sclk        = sclk_r;

endmodule

// File: rtl/spi_bus_controller.sv
// CPU bus slave that turns one byte read/write into a 32-bit mode-0 SPI
// transaction against a 23LC512-style serial SRAM.
module spi_bus_controller #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        bus_done,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    import spi_bus_controller_pkg::*;

    spi_state_t             state_r;
    spi_state_t             state_next_s;
    logic [31:0]            frame_r;
    logic [31:0]            frame_s;
    logic [7:0]             rx_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic                   is_read_r;
    logic                   req_s;
    logic                   last_bit_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   shift_en_s;

    assign req_s      = bus_read | bus_write;
    assign frame_s    = build_frame(bus_read, bus_address_in, bus_data_in);
    assign last_bit_s = (bit_cnt_r == BIT_CNT_W'(SPI_FRAME_BITS - 1));
    assign shift_en_s = (state_r == ST_SHIFT);

    spi_bus_controller_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (shift_en_s),
        .clear       (~shift_en_s),
        .sclk        (spi_sclk),
        .rise_strobe (rise_s),
        .fall_strobe (fall_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; RELEASE blocks the still-held request from retriggering.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (fall_s && last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!req_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RELEASE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered pins: frame shift-out, MISO capture, bus handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r      <= 32'h0000_0000;
            rx_r         <= 8'h00;
            bit_cnt_r    <= '0;
            is_read_r    <= 1'b0;
            bus_data_out <= 8'h00;
            bus_done     <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_mosi     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bus_done <= 1'b0;
                    if (req_s) begin
                        frame_r   <= frame_s;
                        is_read_r <= bus_read;
                        spi_cs_n  <= 1'b0;
                        spi_mosi  <= frame_s[31];
                        bit_cnt_r <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (rise_s) begin
                        rx_r <= {rx_r[6:0], spi_miso};
                    end
                    if (fall_s) begin
                        if (last_bit_s) begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                            spi_mosi  <= frame_r[30];
                            frame_r   <= {frame_r[30:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
                    bus_done <= 1'b1;
                    if (is_read_r) begin
                        bus_data_out <= rx_r;
                    end
                end
                ST_RELEASE: begin
                    bus_done <= 1'b0;
                end
                default: begin
                    bus_done <= 1'b0;
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_controller.sv
// Directed bench: two controller instances (CLK_DIV=1 and 3) share a behavioural
// 23LC512-style SRAM model through a pin multiplexer.
module tb_spi_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        spi_miso = 1'b0;

    logic [7:0] dout1, dout3;
    logic       done1, done3, cs1, cs3, sclk1, sclk3, mosi1, mosi3;
    logic       m_cs_n, m_sclk, m_mosi, m_done;
    logic [7:0] m_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_bus_controller #(.CLK_DIV(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .bus_address_in(addr), .bus_data_in(wdata),
        .bus_data_out(dout1), .bus_read(req_rd & ~sel), .bus_write(req_wr & ~sel),
        .bus_done(done1), .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1),
        .spi_miso(spi_miso));

    spi_bus_controller #(.CLK_DIV(3)) u_slow (
        .clk(clk), .rst_n(rst_n), .bus_address_in(addr), .bus_data_in(wdata),
        .bus_data_out(dout3), .bus_read(req_rd & sel), .bus_write(req_wr & sel),
        .bus_done(done3), .spi_cs_n(cs3), .spi_sclk(sclk3), .spi_mosi(mosi3),
        .spi_miso(spi_miso));

    assign m_cs_n = sel ? cs3   : cs1;
    assign m_sclk = sel ? sclk3 : sclk1;
    assign m_mosi = sel ? mosi3 : mosi1;
    assign m_done = sel ? done3 : done1;
    assign m_dout = sel ? dout3 : dout1;

    // ---------------- SRAM model ----------------
    logic [7:0]  mem [int];
    logic [31:0] cap = 32'h0;
    logic [31:0] last_frame = 32'h0;
    logic [7:0]  cmd_m = 8'h00;
    logic [7:0]  rd_byte = 8'h00;
    int          rises = 0;
    int          cs_falls = 0;
    time         t_rise1 = 0;
    time         t_rise2 = 0;

    function automatic logic [7:0] mem_read(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        if (a == 16'h1234) return 8'hA5;
        if (a == 16'h0001) return 8'h77;
        return 8'h00;
    endfunction

    always @(negedge m_cs_n) begin
        rises = 0;
        cap = 32'h0;
        cs_falls++;
    end

    always @(posedge m_sclk) begin
        if (!m_cs_n) begin
            cap = {cap[30:0], m_mosi};
            rises++;
            if (rises == 1) t_rise1 = $time;
            if (rises == 2) t_rise2 = $time;
            if (rises == 24) begin
                cmd_m = cap[23:16];
                rd_byte = mem_read(cap[15:0]);
            end
        end
    end

    always @(negedge m_sclk) begin
        if (!m_cs_n && cmd_m == 8'h03 && rises >= 24 && rises < 32)
            spi_miso = rd_byte[31 - rises];
    end

    always @(posedge m_cs_n) begin
        last_frame = cap;
        if (rises == 32 && cap[31:24] == 8'h02) mem[int'(cap[23:8])] = cap[7:0];
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at a falling edge; E0 is the next rising edge. Returns at done+1ns.
    task automatic run_txn(input logic s, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [7:0] d, output int cyc);
        @(negedge clk);
        sel = s; req_rd = rd; req_wr = wr; addr = a; wdata = d;
        @(posedge clk);
        cyc = 0;
        #1;
        while (!m_done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_req;
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, m_done}, 32'd0);
    endtask

    int cyc;
    int falls0;
    int n;

    initial begin
        // 1. asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_cs_n", {31'd0, cs1}, 32'd1);
        check("rst_sclk", {31'd0, sclk1}, 32'd0);
        check("rst_mosi", {31'd0, mosi1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_dout", {24'd0, dout1}, 32'h00);
        check("rst_cs_n_slow", {31'd0, cs3}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 2. read 0x1234 -> 0xA5
        run_txn(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, cyc);
        check("rd_latency", cyc, 32'd65);
        check("rd_dout", {24'd0, m_dout}, 32'hA5);
        check("rd_cs_high_at_done", {31'd0, m_cs_n}, 32'd1);
        check("rd_mosi_frame", last_frame, 32'h0312_3400);
        check("rd_sclk_rises", rises, 32'd32);
        release_req();

        // 3. write 0x5C to 0xBEEF
        run_txn(1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h5C, cyc);
        check("wr_latency", cyc, 32'd65);
        check("wr_mosi_frame", last_frame, 32'h02BE_EF5C);
        check("wr_dout_unchanged", {24'd0, m_dout}, 32'hA5);
        check("wr_mem", {31'd0, mem.exists(32'hBEEF)}, 32'd1);
        check("wr_mem_val", {24'd0, mem_read(16'hBEEF)}, 32'h5C);
        release_req();

        // 4. request held after done must not retrigger
        falls0 = cs_falls;
        run_txn(1'b0, 1'b1, 1'b0, 16'hBEEF, 8'h00, cyc);
        check("hold_rd_dout", {24'd0, m_dout}, 32'h5C);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_cs_high", {31'd0, m_cs_n}, 32'd1);
        end
        check("hold_no_new_cs", cs_falls, falls0 + 1);
        @(negedge clk);
        req_rd = 1'b0;
        run_txn(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, cyc);
        check("rearm_latency", cyc, 32'd65);
        check("rearm_dout", {24'd0, m_dout}, 32'hA5);
        check("rearm_cs_falls", cs_falls, falls0 + 2);
        release_req();

        // 5. both requests high: read wins
        run_txn(1'b0, 1'b1, 1'b1, 16'h0001, 8'hEE, cyc);
        check("both_frame", last_frame, 32'h0300_0100);
        check("both_dout", {24'd0, m_dout}, 32'h77);
        check("both_mem_untouched", {31'd0, mem.exists(32'h0001)}, 32'd0);
        release_req();

        // 6a. CLK_DIV=3 read
        run_txn(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00, cyc);
        check("div3_latency", cyc, 32'd193);
        check("div3_sclk_period", 32'(t_rise2 - t_rise1), 32'd60);
        check("div3_dout", {24'd0, m_dout}, 32'hA5);
        release_req();

        // 6b. reset pulse during bit 10 aborts asynchronously
        @(negedge clk);
        sel = 1'b1; req_rd = 1'b1; addr = 16'h1234;
        n = 0;
        while (rises < 11 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_bit10", {31'd0, rises >= 11}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", {31'd0, cs3}, 32'd1);
        check("abort_sclk", {31'd0, sclk3}, 32'd0);
        check("abort_done", {31'd0, done3}, 32'd0);
        req_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00, cyc);
        check("post_rst_latency", cyc, 32'd193);
        check("post_rst_dout", {24'd0, m_dout}, 32'hA5);
        check("post_rst_frame", last_frame, 32'h0312_3400);
        release_req();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
